// File: rtl/axi_register_pkg.sv
// Shared types for the AXI4-Lite register front-end.
// Response codes, controller states and arbiter grant encoding.
package axi_register_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_EXEC,
    WR_RESP,
    RD_EXEC,
    RD_WAIT,
    RD_RESP
  } ctrl_state_t;

  typedef enum logic {
    GRANT_WRITE,
    GRANT_READ
  } grant_t;

  // Decode errors win over alignment errors.
  function automatic resp_t classify(
    input logic out_of_range,
    input logic misaligned
  );
    if (out_of_range) return DECERR;
    if (misaligned) return SLVERR;
    return OKAY;
  endfunction

endpackage

// File: rtl/addr_decoder.sv
// Maps a byte address onto the register window.
// Yields the word offset plus range and alignment flags.
module addr_decoder #(
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int          OffsetWidth = 6
) (
  input  logic [31:0]            addr,
  output logic [OffsetWidth-1:0] offset,
  output logic                   out_of_range,
  output logic                   misaligned
);

  localparam int Lsb = OffsetWidth + 2;

  assign offset       = addr[Lsb-1:2];
  assign out_of_range = addr[31:Lsb] != BaseAddr[31:Lsb];
  assign misaligned   = |addr[1:0];

endmodule

// File: rtl/axi_lite_access_ctrl.sv
// AXI4-Lite slave front-end: arbitrates AW+W against AR,
// runs one register access at a time and returns the response.
module axi_lite_access_ctrl
  import axi_register_pkg::*;
#(
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int          OffsetWidth = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [31:0]            araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [31:0]            rdata,
  output logic [1:0]             rresp,
  output logic                   rvalid,
  input  logic                   rready,
  output logic                   reg_wr_en,
  output logic                   reg_rd_en,
  output logic [OffsetWidth-1:0] reg_offset,
  output logic [31:0]            reg_wdata,
  output logic [3:0]             reg_wstrb,
  input  logic [31:0]            reg_rdata
);

  ctrl_state_t state;
  grant_t      last_grant;
  resp_t       resp_q;
  resp_t       resp_c;

  logic        idle;
  logic        wr_req;
  logic        grant_wr;
  logic        grant_rd;
  logic [31:0] dec_addr;
  logic [OffsetWidth-1:0] dec_offset;
  logic        dec_oor;
  logic        dec_mis;

  assign idle   = state == IDLE;
  assign wr_req = awvalid & wvalid;

  // Round-robin only matters when both sides are pending.
  assign grant_wr = wr_req
                  & (~arvalid | (last_grant == GRANT_READ));
  assign grant_rd = arvalid & ~grant_wr;

  assign awready = idle & grant_wr;
  assign wready  = idle & grant_wr;
  assign arready = idle & grant_rd;

  assign dec_addr = grant_wr ? awaddr : araddr;

  addr_decoder #(
    .BaseAddr    (BaseAddr),
    .OffsetWidth (OffsetWidth)
  ) u_dec (
    .addr         (dec_addr),
    .offset       (dec_offset),
    .out_of_range (dec_oor),
    .misaligned   (dec_mis)
  );

  assign resp_c = classify(dec_oor, dec_mis);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_READ;
      resp_q     <= OKAY;
      rdata      <= '0;
      reg_offset <= '0;
      reg_wdata  <= '0;
      reg_wstrb  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_wr) begin
            state      <= WR_EXEC;
            last_grant <= GRANT_WRITE;
            resp_q     <= resp_c;
            reg_offset <= dec_offset;
            reg_wdata  <= wdata;
            reg_wstrb  <= wstrb;
          end else if (grant_rd) begin
            state      <= RD_EXEC;
            last_grant <= GRANT_READ;
            resp_q     <= resp_c;
            reg_offset <= dec_offset;
          end
        end
        WR_EXEC: state <= WR_RESP;
        WR_RESP: if (bready) state <= IDLE;
        RD_EXEC: state <= RD_WAIT;
        RD_WAIT: begin
          // Error reads never expose register-file data.
          rdata <= (resp_q == OKAY) ? reg_rdata : '0;
          state <= RD_RESP;
        end
        RD_RESP: if (rready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign reg_wr_en = (state == WR_EXEC) & (resp_q == OKAY);
  assign reg_rd_en = (state == RD_EXEC) & (resp_q == OKAY);
  assign bvalid    = state == WR_RESP;
  assign rvalid    = state == RD_RESP;
  assign bresp     = resp_q;
  assign rresp     = resp_q;

endmodule

// File: tb/tb_axi_lite_access_ctrl.sv
// Directed and randomized bench for axi_lite_access_ctrl.
// Register file and expected memory are modelled inside the bench.
module tb_axi_lite_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready;
  logic        reg_wr_en, reg_rd_en;
  logic [5:0]  reg_offset;
  logic [31:0] reg_wdata, reg_rdata;
  logic [3:0]  reg_wstrb;

  int checks;
  int errors;
  int wr_cnt;
  int rd_cnt;

  logic [31:0] rf [64];
  logic [31:0] exp_mem [64];

  always #5 clk = ~clk;

  axi_lite_access_ctrl #(
    .BaseAddr    (32'h0000_0000),
    .OffsetWidth (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .awaddr     (awaddr),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .reg_wr_en  (reg_wr_en),
    .reg_rd_en  (reg_rd_en),
    .reg_offset (reg_offset),
    .reg_wdata  (reg_wdata),
    .reg_wstrb  (reg_wstrb),
    .reg_rdata  (reg_rdata)
  );

  // External register file: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) rf[i] <= '0;
    end else if (reg_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (reg_wstrb[b]) rf[reg_offset][8*b +: 8] <= reg_wdata[8*b +: 8];
    end
    reg_rdata <= reg_rd_en ? rf[reg_offset] : $urandom;
    if (reg_wr_en) wr_cnt <= wr_cnt + 1;
    if (reg_rd_en) rd_cnt <= rd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    if (a >= 32'd256) return 2'b11;
    if ((a % 32'd4) != 32'd0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic [1:0] r;
    logic       ok;
    int         w0;
    int         idx;
    r   = exp_resp(a);
    ok  = (r == 2'b00);
    idx = int'(a / 32'd4);
    w0  = wr_cnt;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    #1;
    chk("wr_awready", 32'(awready), 32'd1);
    chk("wr_wready", 32'(wready), 32'd1);
    chk("wr_arready", 32'(arready), 32'd0);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    chk("wr_strobe", 32'(reg_wr_en), 32'(ok));
    chk("wr_bvalid_early", 32'(bvalid), 32'd0);
    if (ok) begin
      chk("wr_offset", 32'(reg_offset), 32'(idx));
      chk("wr_wdata", reg_wdata, d);
      chk("wr_wstrb", 32'(reg_wstrb), 32'(s));
      for (int b = 0; b < 4; b++)
        if (s[b]) exp_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
    @(negedge clk);
    #1;
    chk("wr_bvalid", 32'(bvalid), 32'd1);
    chk("wr_bresp", 32'(bresp), 32'(r));
    @(negedge clk);
    #1;
    chk("wr_bvalid_done", 32'(bvalid), 32'd0);
    chk("wr_strobe_count", 32'(wr_cnt), 32'(w0 + (ok ? 1 : 0)));
  endtask

  task automatic do_read(input logic [31:0] a);
    logic [1:0] r;
    logic       ok;
    int         r0;
    int         idx;
    r   = exp_resp(a);
    ok  = (r == 2'b00);
    idx = int'(a / 32'd4);
    r0  = rd_cnt;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    #1;
    chk("rd_arready", 32'(arready), 32'd1);
    chk("rd_awready", 32'(awready), 32'd0);
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    chk("rd_strobe", 32'(reg_rd_en), 32'(ok));
    if (ok) chk("rd_offset", 32'(reg_offset), 32'(idx));
    @(negedge clk);
    #1;
    chk("rd_rvalid_early", 32'(rvalid), 32'd0);
    @(negedge clk);
    #1;
    chk("rd_rvalid", 32'(rvalid), 32'd1);
    chk("rd_rresp", 32'(rresp), 32'(r));
    chk("rd_rdata", rdata, ok ? exp_mem[idx] : 32'd0);
    @(negedge clk);
    #1;
    chk("rd_rvalid_done", 32'(rvalid), 32'd0);
    chk("rd_strobe_count", 32'(rd_cnt), 32'(r0 + (ok ? 1 : 0)));
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  got [3];
    int          gcnt;
    int          cyc;
    int          sel;
    int          w0;
    int          r0;

    rst = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b0; rready = 1'b0;
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
    chk("rst_rd_en", 32'(reg_rd_en), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_offset", 32'(reg_offset), 32'd0);
    chk("rst_wdata", reg_wdata, 32'd0);
    chk("rst_wstrb", 32'(reg_wstrb), 32'd0);
    rst = 1'b0;

    do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    do_write(32'h0000_0008, 32'h1234_5678, 4'hF);
    do_read(32'h0000_0008);
    do_read(32'h0000_0010);
    do_write(32'h0000_0100, 32'hCAFE_F00D, 4'hF);
    do_read(32'h0000_0006);
    do_write(32'h0000_0014, 32'h5555_AAAA, 4'h0);
    do_write(32'h0000_0010, 32'h0000_7700, 4'h2);
    do_read(32'h0000_0010);
    do_read(32'h0000_00FC);

    // Back-pressured write response while a read waits.
    w0 = wr_cnt;
    @(negedge clk);
    awaddr = 32'h0000_0400; wdata = 32'h0BAD_0BAD; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    #1;
    chk("bp_awready", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h0000_0008; arvalid = 1'b1; rready = 1'b1;
    #1;
    chk("bp_arready_exec", 32'(arready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("bp_bvalid", 32'(bvalid), 32'd1);
      chk("bp_bresp", 32'(bresp), 32'd3);
      chk("bp_arready", 32'(arready), 32'd0);
    end
    bready = 1'b1;
    #1;
    chk("bp_arready_accept", 32'(arready), 32'd0);
    chk("bp_no_strobe", 32'(wr_cnt), 32'(w0));
    do_read(32'h0000_0008);

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        3: a = 32'($urandom_range(0, 63)) * 32'd4
             + 32'($urandom_range(1, 3));
        4: a = 32'd256 + 32'($urandom_range(0, 65535));
        5: a = $urandom | 32'h8000_0000;
        default: a = 32'($urandom_range(0, 63)) * 32'd4;
      endcase
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)));
      else
        do_read(a);
    end

    // Simultaneous AW+W and AR right after reset: W, R, W.
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;
    awaddr = 32'h0000_0020; wdata = 32'hA5A5_0001; wstrb = 4'hF;
    araddr = 32'h0000_0020;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    bready = 1'b1; rready = 1'b1;
    gcnt = 0;
    cyc = 0;
    while (gcnt < 3 && cyc < 40) begin
      #1;
      if (awready | arready) begin
        got[gcnt] = {awready, arready};
        gcnt++;
      end
      cyc++;
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("rr_grant_count", 32'(gcnt), 32'd3);
    if (gcnt == 3) begin
      chk("rr_grant0", 32'(got[0]), 32'd2);
      chk("rr_grant1", 32'(got[1]), 32'd1);
      chk("rr_grant2", 32'(got[2]), 32'd2);
    end
    repeat (4) @(negedge clk);
    exp_mem[8] = 32'hA5A5_0001;
    do_read(32'h0000_0020);

    // Reset while the read strobe is active.
    @(negedge clk);
    araddr = 32'h0000_0010; arvalid = 1'b1; rready = 1'b1;
    #1;
    chk("mr_arready", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    chk("mr_rd_en_before", 32'(reg_rd_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_rvalid", 32'(rvalid), 32'd0);
    chk("mr_rd_en", 32'(reg_rd_en), 32'd0);
    r0 = rd_cnt;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("mr_post_rvalid", 32'(rvalid), 32'd0);
      chk("mr_post_bvalid", 32'(bvalid), 32'd0);
      chk("mr_post_rd_en", 32'(reg_rd_en), 32'd0);
    end
    chk("mr_rd_count", 32'(rd_cnt), 32'(r0));
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;
    do_read(32'h0000_0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
